inst_fetcher: RTL

//   Front end of the Tomasulo core: holds the PC, looks it up in a direct-mapped

---
 rtl/inst_fetcher.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/inst_fetcher.sv
// Purpose: instruction fetch front end; PC register, direct-mapped one-word-line I-cache, refill via memory controller.
// Latency: hit issues one cycle after lookup; miss issues mem latency + 2 cycles after the request.
// Backpressure: stall_in sampled in the lookup cycle holds the PC; refills proceed regardless of stall_in.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_in                      downstream cannot accept an instruction
//   rob_rollback_in/_target_pc_in redirect PC (priority below rst, above everything else)
//   mc_req_out/mc_addr_out        word-fetch request, held until mc_ready_in
//   mc_ready_in/mc_data_in        one-cycle return pulse with the instruction word
//   dec_issue_out/_inst_out/_pc_out  one-cycle issue pulse to the decoder
module inst_fetcher #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        rob_rollback_in,
    input  logic [31:0] rob_target_pc_in,
    output logic        mc_req_out,
    output logic [31:0] mc_addr_out,
    input  logic        mc_ready_in,
    input  logic [31:0] mc_data_in,
    output logic        dec_issue_out,
    output logic [31:0] dec_inst_out,
    output logic [31:0] dec_pc_out
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

    // DRAIN: a rollback arrived while a refill was outstanding; the refill
    // still completes into the cache but must never produce an issue.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_pc;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES];

    logic [ICACHE_IDX_W-1:0] w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [ICACHE_IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0]        w_fill_tag;
    logic                    w_hit;
    logic                    w_issue;
    logic                    w_req_start;
    logic                    w_fill;

    assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
    assign w_tag      = r_pc[31:ICACHE_IDX_W+2];
    // The refill address is the held request address, not the PC, which may
    // have been redirected by a rollback while the request was outstanding.
    assign w_fill_idx = mc_addr_out[ICACHE_IDX_W+1:2];
    assign w_fill_tag = mc_addr_out[31:ICACHE_IDX_W+2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_req_start = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rob_rollback_in) begin
                    if (w_hit) begin
                        w_issue = !stall_in;
                    end else begin
                        w_req_start = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mc_ready_in) begin
                    w_fill      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (rob_rollback_in) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mc_ready_in) begin
                    w_fill      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_valid       <= '0;
            mc_req_out    <= 1'b0;
            mc_addr_out   <= 32'h0;
            dec_issue_out <= 1'b0;
            dec_inst_out  <= 32'h0;
            dec_pc_out    <= 32'h0;
        end else begin
            dec_issue_out <= w_issue;
            if (w_issue) begin
                dec_inst_out <= r_data[w_idx];
                dec_pc_out   <= r_pc;
            end

            if (rob_rollback_in) begin
                r_pc <= rob_target_pc_in;
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_req_start) begin
                mc_req_out  <= 1'b1;
                mc_addr_out <= r_pc;
            end else if (w_fill) begin
                mc_req_out  <= 1'b0;
            end

            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Line storage needs no reset: a line is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mc_data_in;
        end
    end

endmodule
